// File: rtl/shift_queue_pkg.sv
// shift_queue_pkg: entry-select encodings and default sizing for the shift queue.
package shift_queue_pkg;
   typedef enum logic [1:0] {
      SEL_HOLD  = 2'b00,
      SEL_SHIFT = 2'b01,
      SEL_LOAD  = 2'b10
   } sel_e;
   localparam int W_DEFAULT     = 16;
   localparam int DEPTH_DEFAULT = 4;
endpackage

// File: rtl/queue_entry.sv
// queue_entry: one queue register with a hold/shift/load next-value select.
module queue_entry
   import shift_queue_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  sel_e         sel,
   input  logic [W-1:0] shift_data,
   input  logic [W-1:0] load_data,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (reset) q <= '0;
      else q <= sel == SEL_LOAD ? load_data : sel == SEL_SHIFT ? shift_data : q;
endmodule

// File: rtl/shift_queue_pop.sv
// shift_queue_pop: shift-register queue whose head is always entry 0.
module shift_queue_pop
   import shift_queue_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_p,
   input  logic [W-1:0]  push_data_p,
   output logic          full_p,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [W-1:0]  pop_data,
   output logic [CW-1:0] count,
   output logic          overflow_p
);
   logic [W-1:0]  ent [DEPTH];
   sel_e          sel [DEPTH];
   logic          fire, accept;
   logic [CW-1:0] load_idx;
   assign full_p    = count == CW'(DEPTH);
   assign pop_valid = count != '0;
   assign pop_data  = ent[0];
   assign fire      = pop_valid & pop_ready;
   assign accept    = push_p & (~full_p | fire);
   // A simultaneous pop moves the tail down one slot, so the new item lands one lower.
   assign load_idx  = fire ? count - CW'(1) : count;
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [W-1:0] nxt;
      if (i == DEPTH - 1) begin : g_last
         assign nxt = ent[i];
      end else begin : g_mid
         assign nxt = ent[i+1];
      end
      assign sel[i] = accept && load_idx == CW'(i) ? SEL_LOAD : fire ? SEL_SHIFT : SEL_HOLD;
      queue_entry #(.W(W)) u_entry (
         .clk        (clk),
         .reset      (reset),
         .sel        (sel[i]),
         .shift_data (nxt),
         .load_data  (push_data_p),
         .q          (ent[i])
      );
   end
   always_ff @(posedge clk)
      if (reset) begin
         count      <= '0;
         overflow_p <= 1'b0;
      end else begin
         count      <= accept && !fire ? count + CW'(1) : fire && !accept ? count - CW'(1) : count;
         overflow_p <= push_p & full_p & ~fire;
      end
endmodule

// File: doc/shift_queue_pop.md
SHIFT_QUEUE_POP -- requirements
Module: shift_queue_pop

Interface
REQ-001 Parameter W, default 16, data width in bits.
REQ-002 Parameter DEPTH, default 4, number of queue entries, legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push_p  input  1  writer requests enqueue of push_data_p this cycle.
REQ-006 push_data_p  input  W  enqueue data.
REQ-007 full_p  output  1  high when count == DEPTH.
REQ-008 pop_valid  output  1  head entry holds valid data.
REQ-009 pop_ready  input  1  reader accepts the head entry this cycle.
REQ-010 pop_data  output  W  head entry data.
REQ-011 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-012 overflow_p  output  1  one-cycle pulse: a push was dropped in the previous cycle.

Function
REQ-013 Storage SHALL be DEPTH registers entry[0..DEPTH-1], with entry[0] as head; occupied entries SHALL always be entry[0..count-1].
REQ-014 pop_valid SHALL equal (count != 0); pop_data SHALL equal entry[0] directly from the register, with no combinational path from push_data_p.
REQ-015 A pop fire SHALL occur when pop_valid && pop_ready; on a fire, every entry[i] SHALL load entry[i+1] and entry[DEPTH-1] SHALL hold.
REQ-016 A push SHALL be accepted when push_p && (!full_p || pop fire in the same cycle).
REQ-017 An accepted push without a pop SHALL load push_data_p into entry[count]; an accepted push with a pop SHALL load it into entry[count-1].
REQ-018 Each entry's next value SHALL be chosen by a 3-way select (HOLD, SHIFT, LOAD); for any entry, LOAD SHALL take precedence over SHIFT.
REQ-019 count SHALL increment on a push without a pop, decrement on a pop without a push, and hold otherwise; it SHALL never exceed DEPTH or underflow.
REQ-020 Push-to-pop latency SHALL be 1 cycle: data pushed into an empty queue appears on pop_data with pop_valid high on the next cycle.
REQ-021 With count == 0, push_p and pop_ready asserted together SHALL perform the push only; no bypass is permitted.
REQ-022 With count == DEPTH, push_p and a pop fire together SHALL accept the push, and count SHALL stay at DEPTH.
REQ-023 With push_p asserted, full_p high and no pop fire, the push SHALL be dropped, storage and count SHALL be unchanged, and overflow_p SHALL be high for exactly the next cycle.
REQ-024 pop_ready asserted while pop_valid is low SHALL have no effect.
REQ-025 Unoccupied entries SHALL hold their contents; their values are don't-care.

Reset
REQ-026 While reset is high at a clock edge: count = 0, all entries = 0, overflow_p = 0; hence pop_valid = 0, full_p = 0 and pop_data = 0 on the following cycle.
REQ-027 Reset SHALL take precedence over push and pop in the same cycle, and a reset mid-operation SHALL discard all queued data.
REQ-028 Push and pop inputs SHALL be ignored during any cycle in which reset is high.

Structure
REQ-029 Package shift_queue_pkg SHALL hold the entry-select encodings SEL_HOLD = 2'b00, SEL_SHIFT = 2'b01 and SEL_LOAD = 2'b10, and the default W and DEPTH constants.
REQ-030 The per-entry register SHALL be the sub-module queue_entry (W-bit reset flop plus 3-way next-value mux), instantiated DEPTH times with a generate loop.
REQ-031 Select generation, count and overflow logic SHALL reside in shift_queue_pop itself.

Verification
REQ-032 Reset, then push 0x1111 and 0x2222 on consecutive cycles, pop_ready = 0 -> count = 2, pop_data = 0x1111, pop_valid = 1.
REQ-033 Fill 0xA0..0xA3 (DEPTH = 4), then push 0xFF without a pop -> full_p = 1, count = 4, overflow_p pulses one cycle, and the pops return 0xA0..0xA3 in order.
REQ-034 Full queue, push 0xB4 with pop_ready = 1 -> pops 0xA0, count stays 4, and the remaining order is 0xA1, 0xA2, 0xA3, 0xB4.
REQ-035 Empty queue, push 0x55 with pop_ready = 1 -> no pop that cycle; next cycle pop_valid = 1 and pop_data = 0x55.
REQ-036 Count = 3, reset asserted together with push_p and pop_ready -> next cycle count = 0, pop_valid = 0, pop_data = 0, overflow_p = 0.
REQ-037 Random push/pop for 10k cycles against a reference queue model -> no data mismatch, count always in 0..DEPTH.
